// File: rtl/irq_pending_latch.sv
`default_nettype none
// ============================================================================
// Module      : irq_pending_latch
// Description : Request-capture stage in front of an 8-bit priority encoder.
//               Latches raw requests into a maskable pending vector, presents
//               the encoder's winner on a valid/ack handshake and clears the
//               serviced bit on acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_pending_latch #(
    parameter bit EDGE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic       ovf_clr,
    output logic [7:0] enc_in,
    input  logic [2:0] enc_code,
    input  logic       enc_z,
    output logic [7:0] pending,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] overflow
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_req_d;
    logic [7:0] r_pending;
    logic [7:0] r_overflow;
    logic [2:0] r_irq_id;
    logic       r_irq_valid;

    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic       w_ack_hit;

    // req_d also loads during reset so a line held high across release is
    // not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        r_req_d <= req;
    end

    generate
        if (EDGE) begin : g_edge
            assign w_set = req & ~r_req_d;
        end else begin : g_level
            assign w_set = req;
        end
    endgenerate

    assign w_ack_hit = ack & r_irq_valid;
    assign w_clr     = w_ack_hit ? (8'b0000_0001 << r_irq_id) : 8'b0000_0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= 8'h00;
            r_overflow <= 8'h00;
        end else begin
            // set beats clear, and a fresh overflow beats ovf_clr
            r_pending  <= w_set | (r_pending & ~w_clr);
            r_overflow <= (w_set & r_pending & ~w_clr)
                        | (r_overflow & ~{8{ovf_clr}});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_irq_id    <= 3'd0;
            r_irq_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!enc_z) begin
                        r_irq_id    <= enc_code;
                        r_irq_valid <= 1'b1;
                        r_state     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // irq_id is frozen here: no preemption by later arrivals
                    if (ack) begin
                        r_irq_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_irq_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign enc_in    = r_pending & mask;
    assign pending   = r_pending;
    assign overflow  = r_overflow;
    assign irq_valid = r_irq_valid;
    assign irq_id    = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_pending_latch
// Description : Directed, table-driven bench for edge and level instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_pending_latch;

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic       ovf_clr;
        logic [7:0] exp_pending;
        logic [7:0] exp_enc_in;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic [7:0] exp_ovf;
    } vec_t;

    logic       clk;
    logic       reset;

    logic [7:0] req_e, mask_e, enc_in_e, pending_e, overflow_e;
    logic       ack_e, ovf_clr_e, enc_z_e, irq_valid_e;
    logic [2:0] enc_code_e, irq_id_e;

    logic [7:0] req_l, mask_l, enc_in_l, pending_l, overflow_l;
    logic       ack_l, ovf_clr_l, enc_z_l, irq_valid_l;
    logic [2:0] enc_code_l, irq_id_l;

    int errors;
    int checks;

    irq_pending_latch #(.EDGE(1'b1)) u_edge (
        .clk(clk), .reset(reset), .req(req_e), .mask(mask_e), .ack(ack_e),
        .ovf_clr(ovf_clr_e), .enc_in(enc_in_e), .enc_code(enc_code_e),
        .enc_z(enc_z_e), .pending(pending_e), .irq_valid(irq_valid_e),
        .irq_id(irq_id_e), .overflow(overflow_e)
    );

    irq_pending_latch #(.EDGE(1'b0)) u_level (
        .clk(clk), .reset(reset), .req(req_l), .mask(mask_l), .ack(ack_l),
        .ovf_clr(ovf_clr_l), .enc_in(enc_in_l), .enc_code(enc_code_l),
        .enc_z(enc_z_l), .pending(pending_l), .irq_valid(irq_valid_l),
        .irq_id(irq_id_l), .overflow(overflow_l)
    );

    // Reference priority encoders: index of the highest set bit.
    always_comb begin
        enc_code_e = 3'd0;
        for (int i = 0; i < 8; i++) if (enc_in_e[i]) enc_code_e = 3'(i);
        enc_z_e = (enc_in_e == 8'h00);
    end

    always_comb begin
        enc_code_l = 3'd0;
        for (int i = 0; i < 8; i++) if (enc_in_l[i]) enc_code_l = 3'(i);
        enc_z_l = (enc_in_l == 8'h00);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [7:0] r, input logic [7:0] m,
                               input logic a, input logic oc,
                               input logic [7:0] p, input logic [7:0] e,
                               input logic vl, input logic [2:0] id,
                               input logic [7:0] o);
        vec_t t;
        t.req = r; t.mask = m; t.ack = a; t.ovf_clr = oc;
        t.exp_pending = p; t.exp_enc_in = e; t.exp_valid = vl;
        t.exp_id = id; t.exp_ovf = o;
        return t;
    endfunction

    vec_t tbl_e[$];
    vec_t tbl_l[$];

    initial begin
        errors = 0;
        checks = 0;

        //                 req    mask   ack  oc    pend   enc    vld  id    ovf
        // reset release with req held high: no edge
        tbl_e.push_back(v(8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00));
        // single edge on line 3
        tbl_e.push_back(v(8'h08, 8'hFF, 0, 0, 8'h08, 8'h08, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h08, 8'h08, 1, 3'd3, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h08, 8'h08, 1, 3'd3, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00));
        // priority: 7 before 1, one idle cycle between
        tbl_e.push_back(v(8'h82, 8'hFF, 0, 0, 8'h82, 8'h82, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h82, 8'h82, 1, 3'd7, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 1, 0, 8'h02, 8'h02, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h02, 8'h02, 1, 3'd1, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00));
        // masked line 5 accumulates, presented once unmasked
        tbl_e.push_back(v(8'h20, 8'hDF, 0, 0, 8'h20, 8'h00, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hDF, 0, 0, 8'h20, 8'h00, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h20, 8'h20, 1, 3'd5, 8'h00));
        // line 6 arrives and mask drops during PRESENT: id 5 held
        tbl_e.push_back(v(8'h40, 8'hFF, 0, 0, 8'h60, 8'h60, 1, 3'd5, 8'h00));
        tbl_e.push_back(v(8'h40, 8'h00, 0, 0, 8'h60, 8'h00, 1, 3'd5, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 1, 0, 8'h40, 8'h40, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h40, 8'h40, 1, 3'd6, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00));
        // overflow on line 2, then ovf_clr
        tbl_e.push_back(v(8'h04, 8'hFF, 0, 0, 8'h04, 8'h04, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h04, 8'h04, 1, 3'd2, 8'h00));
        tbl_e.push_back(v(8'h04, 8'hFF, 0, 0, 8'h04, 8'h04, 1, 3'd2, 8'h04));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 1, 8'h04, 8'h04, 1, 3'd2, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h04, 8'h04, 1, 3'd2, 8'h00));
        // edge on line 2 together with its ack: stays pending, no overflow
        tbl_e.push_back(v(8'h04, 8'hFF, 1, 0, 8'h04, 8'h04, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h04, 8'h04, 1, 3'd2, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00));
        // new overflow beats ovf_clr in the same cycle
        tbl_e.push_back(v(8'h04, 8'hFF, 0, 0, 8'h04, 8'h04, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h04, 8'h04, 1, 3'd2, 8'h00));
        tbl_e.push_back(v(8'h04, 8'hFF, 0, 1, 8'h04, 8'h04, 1, 3'd2, 8'h04));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 1, 8'h04, 8'h04, 1, 3'd2, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00));
        // ack in IDLE on the stale irq_id line is ignored
        tbl_e.push_back(v(8'h04, 8'h00, 1, 0, 8'h04, 8'h00, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'h00, 1, 0, 8'h04, 8'h00, 0, 3'd0, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 0, 0, 8'h04, 8'h04, 1, 3'd2, 8'h00));
        tbl_e.push_back(v(8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00));

        // level mode: line 0 held high is re-presented after every ack
        tbl_l.push_back(v(8'h01, 8'hFF, 0, 0, 8'h01, 8'h01, 0, 3'd0, 8'h00));
        tbl_l.push_back(v(8'h01, 8'hFF, 0, 0, 8'h01, 8'h01, 1, 3'd0, 8'h01));
        tbl_l.push_back(v(8'h01, 8'hFF, 1, 0, 8'h01, 8'h01, 0, 3'd0, 8'h01));
        tbl_l.push_back(v(8'h01, 8'hFF, 0, 0, 8'h01, 8'h01, 1, 3'd0, 8'h01));
        tbl_l.push_back(v(8'h01, 8'hFF, 1, 0, 8'h01, 8'h01, 0, 3'd0, 8'h01));
        tbl_l.push_back(v(8'h01, 8'hFF, 0, 0, 8'h01, 8'h01, 1, 3'd0, 8'h01));
        tbl_l.push_back(v(8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 3'd0, 8'h01));
        tbl_l.push_back(v(8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 3'd0, 8'h01));

        // reset with all request lines high
        reset = 1'b1;
        req_e = 8'hFF; mask_e = 8'hFF; ack_e = 1'b0; ovf_clr_e = 1'b0;
        req_l = 8'h00; mask_l = 8'hFF; ack_l = 1'b0; ovf_clr_l = 1'b0;
        tick();
        tick();
        chk("reset pending",   pending_e, 8'h00);
        chk("reset overflow",  overflow_e, 8'h00);
        chk("reset irq_valid", {7'd0, irq_valid_e}, 8'h00);
        chk("reset irq_id",    {5'd0, irq_id_e}, 8'h00);
        chk("reset enc_in",    enc_in_e, 8'h00);
        reset = 1'b0;

        foreach (tbl_e[i]) begin
            req_e = tbl_e[i].req; mask_e = tbl_e[i].mask;
            ack_e = tbl_e[i].ack; ovf_clr_e = tbl_e[i].ovf_clr;
            tick();
            chk($sformatf("edge[%0d] pending", i),  pending_e,  tbl_e[i].exp_pending);
            chk($sformatf("edge[%0d] enc_in", i),   enc_in_e,   tbl_e[i].exp_enc_in);
            chk($sformatf("edge[%0d] valid", i),    {7'd0, irq_valid_e}, {7'd0, tbl_e[i].exp_valid});
            chk($sformatf("edge[%0d] overflow", i), overflow_e, tbl_e[i].exp_ovf);
            if (tbl_e[i].exp_valid)
                chk($sformatf("edge[%0d] irq_id", i), {5'd0, irq_id_e}, {5'd0, tbl_e[i].exp_id});
        end

        // reset mid-PRESENT together with ack and a pending overflow
        req_e = 8'h10; ack_e = 1'b0; mask_e = 8'hFF;
        tick();
        req_e = 8'h00;
        tick();
        req_e = 8'h10;
        tick();
        chk("pre-reset valid",    {7'd0, irq_valid_e}, 8'h01);
        chk("pre-reset irq_id",   {5'd0, irq_id_e}, 8'h04);
        chk("pre-reset overflow", overflow_e, 8'h10);
        reset = 1'b1; ack_e = 1'b1; req_e = 8'h00;
        tick();
        chk("mid reset pending",  pending_e, 8'h00);
        chk("mid reset valid",    {7'd0, irq_valid_e}, 8'h00);
        chk("mid reset irq_id",   {5'd0, irq_id_e}, 8'h00);
        chk("mid reset overflow", overflow_e, 8'h00);
        reset = 1'b0; ack_e = 1'b0;
        tick();
        chk("post reset pending", pending_e, 8'h00);
        chk("post reset valid",   {7'd0, irq_valid_e}, 8'h00);

        foreach (tbl_l[i]) begin
            req_l = tbl_l[i].req; mask_l = tbl_l[i].mask;
            ack_l = tbl_l[i].ack; ovf_clr_l = tbl_l[i].ovf_clr;
            tick();
            chk($sformatf("level[%0d] pending", i),  pending_l,  tbl_l[i].exp_pending);
            chk($sformatf("level[%0d] enc_in", i),   enc_in_l,   tbl_l[i].exp_enc_in);
            chk($sformatf("level[%0d] valid", i),    {7'd0, irq_valid_l}, {7'd0, tbl_l[i].exp_valid});
            chk($sformatf("level[%0d] overflow", i), overflow_l, tbl_l[i].exp_ovf);
            if (tbl_l[i].exp_valid)
                chk($sformatf("level[%0d] irq_id", i), {5'd0, irq_id_l}, {5'd0, tbl_l[i].exp_id});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
